// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word size, NOP encoding, default
// reset PC, the {pc, instr} entry type and a word-alignment helper.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    // Opcode encodings shared with decode.
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Width of the stale-response counter. Dropped responses do not consume
    // queue credit, so this only has to cover a burst of redirects that each
    // strand up to QDEPTH requests.
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
//
// Handshakes: a transfer happens in any cycle where valid && ready are both
// high at the rising edge. The request side keeps valid/addr stable until
// accepted, except that a redirect cycle may withdraw valid. The response
// side has no ready: a valid response is always consumed. On the decode side
// the head is offered with id_valid and leaves the queue when id_ready is high.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redir_valid, redir_pc, id_ready
    );

    // Memory / EX / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redir_valid, redir_pc, id_ready
    );

endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries. Pointers carry an extra MSB
// so full and empty are distinguishable; flush empties it in one cycle.
module if_fetch_unit_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    input  logic                    flush,
    output fetch_entry_t            head,
    output logic                    empty,
    output logic [$clog2(QDEPTH):0] count
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    fetch_entry_t mem [QDEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointer update; flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests
// under a credit limit so returning words always fit in the queue, drops
// responses that belong to a squashed path, and feeds decode from the queue.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    if_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]       QD_LIM   = QDEPTH[CW:0];
    localparam logic [XLEN-1:0]   PC_STEP  = 32'd4;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    logic              fetch_en;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [XLEN-1:0]   pc_hold;
    logic [CW-1:0]     outstanding;
    logic [DROP_W-1:0] drop_cnt;

    logic [CW-1:0]     q_count;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;

    logic [CW:0]       inflight;
    logic              req_valid;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_take;
    logic              q_push;
    logic              q_pop;

    // Words already buffered plus words still owed by memory must fit.
    assign inflight  = {1'b0, q_count} + {1'b0, outstanding};
    assign req_valid = fetch_en && !bus.redir_valid && (inflight < QD_LIM);
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Stale responses from a squashed path are consumed by drop_cnt first.
    assign resp_drop = bus.imem_resp_valid && (drop_cnt != '0);
    assign resp_take = bus.imem_resp_valid && (drop_cnt == '0);
    assign q_push    = resp_take && !bus.redir_valid;
    assign q_pop     = !q_empty && bus.id_ready;

    assign push_entry = '{pc: resp_pc, instr: bus.imem_resp_data};

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.id_valid       = !q_empty;
    assign bus.id_instr       = q_empty ? NOP_INSTR : q_head.instr;
    assign bus.id_pc          = q_empty ? pc_hold   : q_head.pc;

    if_fetch_unit_fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (bus.redir_valid),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Hold off requests until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_en <= 1'b0;
        else        fetch_en <= 1'b1;
    end

    // Fetch PC, response PC and the outstanding/drop credit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redir_valid) begin
            fetch_pc    <= word_align(bus.redir_pc);
            resp_pc     <= word_align(bus.redir_pc);
            outstanding <= '0;
            // Every owed word becomes stale; a same-cycle response retires one
            // either from drop_cnt or from outstanding, so the net is -1.
            drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(bus.imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (q_push)   resp_pc  <= resp_pc + PC_STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            if (resp_drop) drop_cnt <= drop_cnt - DROP_ONE;
        end
    end

    // Remember the last presented PC so id_pc holds while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_hold <= '0;
        else        pc_hold <= bus.id_pc;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a behavioural instruction memory with
// selectable 1- or 2-cycle latency returning addr ^ 32'hA5A5_0000, a negedge
// monitor logging request and decode handshakes, and one task per scenario.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;
    localparam logic [31:0] NONE = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus2 ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_wrap (
        .clk (clk), .rst_n (rst_n), .bus (bus2)
    );

    // ---------------- memory models ----------------
    int          mem_lat = 1;
    logic        s1_v;
    logic [31:0] s1_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= '0;
        end else if (mem_lat == 1) begin
            bus.imem_resp_valid <= bus.imem_req_valid && bus.imem_req_ready;
            bus.imem_resp_data  <= bus.imem_req_addr ^ K;
            s1_v <= 1'b0;
        end else begin
            bus.imem_resp_valid <= s1_v;
            bus.imem_resp_data  <= s1_d;
            s1_v <= bus.imem_req_valid && bus.imem_req_ready;
            s1_d <= bus.imem_req_addr ^ K;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus2.imem_resp_valid <= 1'b0;
            bus2.imem_resp_data  <= '0;
        end else begin
            bus2.imem_resp_valid <= bus2.imem_req_valid && bus2.imem_req_ready;
            bus2.imem_resp_data  <= bus2.imem_req_addr ^ K;
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          first_req_cyc = -1;
    int          first_pop_cyc = -1;
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_in_q[$];
    logic [31:0] req2_q[$];
    logic [31:0] pop2_pc_q[$];
    logic [31:0] pop2_in_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                req_q.push_back(bus.imem_req_addr);
            end
            if (bus.id_valid && bus.id_ready) begin
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                pop_pc_q.push_back(bus.id_pc);
                pop_in_q.push_back(bus.id_instr);
            end
            if (bus2.imem_req_valid && bus2.imem_req_ready) req2_q.push_back(bus2.imem_req_addr);
            if (bus2.id_valid && bus2.id_ready) begin
                pop2_pc_q.push_back(bus2.id_pc);
                pop2_in_q.push_back(bus2.id_instr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_q.delete();
        pop_pc_q.delete();
        pop_in_q.delete();
        req2_q.delete();
        pop2_pc_q.delete();
        pop2_in_q.delete();
        first_req_cyc = -1;
        first_pop_cyc = -1;
    endtask

    // Assert reset for two edges, release 1 time unit after an edge.
    task automatic do_reset();
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        rst_n = 1'b0;
        tick();
        tick();
        clear_logs();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", bus.imem_req_valid); end
        n_vec++; if (bus.id_instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_id_instr got %h want 00000013", bus.id_instr); end
        n_vec++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc got %h want 0", bus.id_pc); end
        n_vec++; if (bus.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL reset_req_addr got %h want 0", bus.imem_req_addr); end
        n_vec++; if (bus2.imem_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_req_addr_wrap got %h want fffffff8", bus2.imem_req_addr); end
        n_vec++; if (bus2.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid_wrap got %b want 0", bus2.imem_req_valid); end
    endtask

    task automatic test_stream();
        mem_lat = 1;
        bus.id_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        do_reset();
        repeat (10) tick();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        n_vec++; if (req_q.size() < 4) begin n_err++; $display("FAIL stream_req_count got %0d want >=4", req_q.size()); end
        n_vec++; if (pop_pc_q.size() < 4) begin n_err++; $display("FAIL stream_pop_count got %0d want >=4", pop_pc_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < req_q.size()) ? req_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL stream_req_addr[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL stream_id_pc[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop_in_q.size()) ? pop_in_q[i] : NONE;
            n_vec++; if (got !== (exp_q[i] ^ K)) begin n_err++; $display("FAIL stream_id_instr[%0d] got %h want %h", i, got, exp_q[i] ^ K); end
        end
        n_vec++; if ((first_pop_cyc - first_req_cyc) !== 2) begin n_err++; $display("FAIL stream_first_latency got %0d want 2", first_pop_cyc - first_req_cyc); end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        bus.id_ready = 1'b0;
        bus.imem_req_ready = 1'b1;
        do_reset();
        repeat (10) tick();
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_valid got %b want 0", bus.imem_req_valid); end
        n_vec++; if (req_q.size() !== 4) begin n_err++; $display("FAIL stall_req_count got %0d want 4", req_q.size()); end
        n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL stall_id_valid got %b want 1", bus.id_valid); end
        n_vec++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL stall_head_pc got %h want 0", bus.id_pc); end
        n_vec++; if (bus.id_instr !== K) begin n_err++; $display("FAIL stall_head_instr got %h want %h", bus.id_instr, K); end
        clear_logs();
        bus.id_ready = 1'b1;
        repeat (10) tick();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 5; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL stall_drain_pc[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop_in_q.size()) ? pop_in_q[i] : NONE;
            n_vec++; if (got !== (exp_q[i] ^ K)) begin n_err++; $display("FAIL stall_drain_instr[%0d] got %h want %h", i, got, exp_q[i] ^ K); end
        end
        got = (req_q.size() > 0) ? req_q[0] : NONE;
        n_vec++; if (got !== 32'h10) begin n_err++; $display("FAIL stall_resume_addr got %h want 00000010", got); end
    endtask

    task automatic test_redirect();
        int stale;
        mem_lat = 2;
        bus.id_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && req_q.size() < 2; i++) tick();
        n_vec++; if (req_q.size() !== 2) begin n_err++; $display("FAIL redir_setup_timeout got %0d reqs want 2", req_q.size()); end
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h100;
        #1;
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_no_req got %b want 0", bus.imem_req_valid); end
        tick();
        bus.redir_valid = 1'b0;
        #1;
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_id_valid got %b want 0", bus.id_valid); end
        n_vec++; if (bus.imem_req_addr !== 32'h100) begin n_err++; $display("FAIL redir_new_addr got %h want 00000100", bus.imem_req_addr); end
        n_vec++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL redir_new_req_valid got %b want 1", bus.imem_req_valid); end
        repeat (12) tick();
        exp_q = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL redir_id_pc[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop_in_q.size()) ? pop_in_q[i] : NONE;
            n_vec++; if (got !== (exp_q[i] ^ K)) begin n_err++; $display("FAIL redir_id_instr[%0d] got %h want %h", i, got, exp_q[i] ^ K); end
        end
        stale = 0;
        foreach (pop_pc_q[i]) if (pop_pc_q[i] < 32'h100) stale++;
        n_vec++; if (stale !== 0) begin n_err++; $display("FAIL redir_stale_words got %0d want 0", stale); end
    endtask

    task automatic test_redirect_pop();
        mem_lat = 1;
        bus.id_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && pop_pc_q.size() < 1; i++) tick();
        n_vec++; if (pop_pc_q.size() !== 1) begin n_err++; $display("FAIL rpop_setup_timeout got %0d pops want 1", pop_pc_q.size()); end
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h203;
        #1;
        n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL rpop_head_valid got %b want 1", bus.id_valid); end
        n_vec++; if (bus.id_pc !== 32'h4) begin n_err++; $display("FAIL rpop_head_pc got %h want 00000004", bus.id_pc); end
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rpop_no_req got %b want 0", bus.imem_req_valid); end
        tick();
        bus.redir_valid = 1'b0;
        #1;
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL rpop_flush_id_valid got %b want 0", bus.id_valid); end
        n_vec++; if (bus.imem_req_addr !== 32'h200) begin n_err++; $display("FAIL rpop_new_addr got %h want 00000200", bus.imem_req_addr); end
        repeat (10) tick();
        exp_q = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
        for (int i = 0; i < 5; i++) begin
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL rpop_id_pc[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
        for (int i = 0; i < 5; i++) begin
            got = (i < req_q.size()) ? req_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL rpop_req_addr[%0d] got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        repeat (8) tick();
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            got = (i < req2_q.size()) ? req2_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL wrap_req_addr[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop2_pc_q.size()) ? pop2_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL wrap_id_pc[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop2_in_q.size()) ? pop2_in_q[i] : NONE;
            n_vec++; if (got !== (exp_q[i] ^ K)) begin n_err++; $display("FAIL wrap_id_instr[%0d] got %h want %h", i, got, exp_q[i] ^ K); end
        end
    endtask

    task automatic test_async_reset();
        mem_lat = 1;
        bus.id_ready = 1'b0;
        bus.imem_req_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && req_q.size() < 3; i++) tick();
        bus.imem_req_ready = 1'b0;
        repeat (2) tick();
        n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_id_valid got %b want 1", bus.id_valid); end
        n_vec++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_req_valid got %b want 1", bus.imem_req_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL arst_id_valid got %b want 0", bus.id_valid); end
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL arst_req_valid got %b want 0", bus.imem_req_valid); end
        n_vec++; if (bus.id_instr !== 32'h0000_0013) begin n_err++; $display("FAIL arst_id_instr got %h want 00000013", bus.id_instr); end
        n_vec++; if (bus.imem_req_addr !== 32'h0) begin n_err++; $display("FAIL arst_req_addr got %h want 0", bus.imem_req_addr); end
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        do_reset();
        repeat (10) tick();
        exp_q = '{32'h0, 32'h4};
        for (int i = 0; i < 2; i++) begin
            got = (i < req_q.size()) ? req_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL arst_restart_addr[%0d] got %h want %h", i, got, exp_q[i]); end
            got = (i < pop_pc_q.size()) ? pop_pc_q[i] : NONE;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL arst_restart_pc[%0d] got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.id_ready        = 1'b1;
        bus.redir_valid     = 1'b0;
        bus.redir_pc        = '0;
        bus2.imem_req_ready = 1'b1;
        bus2.id_ready       = 1'b1;
        bus2.redir_valid    = 1'b0;
        bus2.redir_pc       = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
